// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer slice.
package stopwatch_pkg;

  // bit 1 = adjust axis, bit 0 = pause axis
  typedef enum logic [1:0] {
    NORM_RUN    = 2'b00,
    NORM_PAUSED = 2'b01,
    ADJ_RUN     = 2'b10,
    ADJ_PAUSED  = 2'b11
  } seq_state_e;

  localparam logic [1:0] COUNT_MODE_CARRY = 2'b00;
  localparam logic [1:0] COUNT_MODE_SEC   = 2'b01;
  localparam logic [1:0] COUNT_MODE_MIN   = 2'b10;

  localparam int NUM_DIGITS = 4;

  localparam logic [NUM_DIGITS-1:0] ANODE_D0 = 4'b0111;
  localparam logic [NUM_DIGITS-1:0] ANODE_D1 = 4'b1011;
  localparam logic [NUM_DIGITS-1:0] ANODE_D2 = 4'b1101;
  localparam logic [NUM_DIGITS-1:0] ANODE_D3 = 4'b1110;

  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [1:0] digit);
    case (digit)
      2'd0:    anode_for = ANODE_D0;
      2'd1:    anode_for = ANODE_D1;
      2'd2:    anode_for = ANODE_D2;
      default: anode_for = ANODE_D3;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_sequencer_sync_edge_detect.sv
// Level synchronizer with rising-edge detect. STAGES=1 treats the input as already
// synchronous, so the only flop is the edge history (reset to 1 to mask held inputs).
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic in_clock,
  input  logic in_reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic hist_q;

  generate
    if (STAGES <= 1) begin : g_direct
      assign level_o = d_i;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;
      always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], d_i};
      end
      assign level_o = sync_q[STAGES-1];
    end
  endgenerate

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) hist_q <= 1'b1;
    else          hist_q <= level_o;
  end

  assign rise_o = level_o & ~hist_q;

endmodule

// File: rtl/stopwatch_sequencer.sv
// Enable-based run/pause/adjust sequencer and digit scanner for the MM:SS stopwatch.
// Optional colon on digit 1 via the decimal point: define SEQ_COLON_DP_EN.
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_pause_btn,
  input  logic       in_clear_btn,
  input  logic       in_adjust_sw,
  input  logic       in_select_sw,
  input  logic       in_tick_1hz,
  input  logic       in_tick_2hz,
  input  logic       in_tick_scan,
  input  logic       in_blink_phase,
  output logic       out_count_en,
  output logic [1:0] out_count_mode,
  output logic       out_clear,
  output logic [1:0] out_digit_sel,
  output logic [3:0] out_anode,
  output logic       out_blank,
  output logic       out_paused,
  output logic       out_dp
);

  logic adj_s, sel_s, pause_rise, clear_rise;
  logic adj_rise, sel_rise, pause_lvl, clear_lvl;
  logic unused_taps;
  assign unused_taps = ^{adj_rise, sel_rise, pause_lvl, clear_lvl};

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_adj_sync (
    .in_clock(in_clock), .in_reset(in_reset), .d_i(in_adjust_sw),
    .level_o(adj_s), .rise_o(adj_rise));

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sel_sync (
    .in_clock(in_clock), .in_reset(in_reset), .d_i(in_select_sw),
    .level_o(sel_s), .rise_o(sel_rise));

  sync_edge_detect #(.STAGES(1)) u_pause_edge (
    .in_clock(in_clock), .in_reset(in_reset), .d_i(in_pause_btn),
    .level_o(pause_lvl), .rise_o(pause_rise));

  sync_edge_detect #(.STAGES(1)) u_clear_edge (
    .in_clock(in_clock), .in_reset(in_reset), .d_i(in_clear_btn),
    .level_o(clear_lvl), .rise_o(clear_rise));

  seq_state_e state_q, state_d;
  logic       count_en_q, count_en_d;
  logic [1:0] count_mode_q, count_mode_d;
  logic       clear_q, clear_d;
  logic [1:0] digit_q, digit_d;
  logic [3:0] anode_q, anode_d;
  logic       blank_q, blank_d;
  logic       paused_q, pause_axis_d;
  logic       dp_d;

  // Every decision below is taken against state_q, i.e. the state before this edge.
  always_comb begin
    pause_axis_d = state_q[0] ^ pause_rise;
    state_d      = seq_state_e'({adj_s, pause_axis_d});
    count_en_d   = 1'b0;
    count_mode_d = count_mode_q;
    clear_d      = clear_rise;
    if (!clear_rise) begin
      if (state_q == NORM_RUN && in_tick_1hz) begin
        count_en_d   = 1'b1;
        count_mode_d = COUNT_MODE_CARRY;
      end else if (state_q == ADJ_RUN && in_tick_2hz) begin
        count_en_d   = 1'b1;
        count_mode_d = sel_s ? COUNT_MODE_SEC : COUNT_MODE_MIN;
      end
    end
    digit_d = digit_q;
    anode_d = anode_q;
    blank_d = blank_q;
    if (in_tick_scan) begin
      digit_d = digit_q + 2'd1;
      anode_d = anode_for(digit_d);
      blank_d = state_q[1] && !in_blink_phase && (digit_d[1] == sel_s);
    end
    dp_d = ~((digit_d == 2'd1) &&
             ((state_q == NORM_RUN && in_blink_phase) || state_q == NORM_PAUSED));
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q      <= NORM_RUN;
      count_en_q   <= 1'b0;
      count_mode_q <= COUNT_MODE_CARRY;
      clear_q      <= 1'b0;
      digit_q      <= 2'd0;
      anode_q      <= ANODE_D0;
      blank_q      <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_en_q   <= count_en_d;
      count_mode_q <= count_mode_d;
      clear_q      <= clear_d;
      digit_q      <= digit_d;
      anode_q      <= anode_d;
      blank_q      <= blank_d;
      paused_q     <= pause_axis_d;
    end
  end

`ifdef SEQ_COLON_DP_EN
  logic dp_q;
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) dp_q <= 1'b1;
    else          dp_q <= dp_d;
  end
  assign out_dp = dp_q;
`else
  logic unused_dp;
  assign unused_dp = dp_d;
  assign out_dp    = 1'b1;
`endif

  assign out_count_en   = count_en_q;
  assign out_count_mode = count_mode_q;
  assign out_clear      = clear_q;
  assign out_digit_sel  = digit_q;
  assign out_anode      = anode_q;
  assign out_blank      = blank_q;
  assign out_paused     = paused_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer with hand-computed expectations.
module tb_stopwatch_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause_btn = 1'b0, clear_btn = 1'b0, adjust_sw = 1'b0, select_sw = 1'b0;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0, tick_scan = 1'b0, blink = 1'b0;
  logic       count_en, clear_o, blank, paused, dp;
  logic [1:0] count_mode, digit_sel;
  logic [3:0] anode;

  int checks = 0;
  int errors = 0;

  stopwatch_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .in_clock(clk), .in_reset(rst),
    .in_pause_btn(pause_btn), .in_clear_btn(clear_btn),
    .in_adjust_sw(adjust_sw), .in_select_sw(select_sw),
    .in_tick_1hz(tick_1hz), .in_tick_2hz(tick_2hz), .in_tick_scan(tick_scan),
    .in_blink_phase(blink),
    .out_count_en(count_en), .out_count_mode(count_mode), .out_clear(clear_o),
    .out_digit_sel(digit_sel), .out_anode(anode), .out_blank(blank),
    .out_paused(paused), .out_dp(dp));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick1();
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
  endtask

  task automatic do_tick2();
    tick_2hz = 1'b1; step(); tick_2hz = 1'b0;
  endtask

  task automatic do_scan();
    tick_scan = 1'b1; step(); tick_scan = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_en"},     8'(count_en),   8'h0);
    check_eq({tag, "_mode"},   8'(count_mode), 8'h0);
    check_eq({tag, "_clear"},  8'(clear_o),    8'h0);
    check_eq({tag, "_digit"},  8'(digit_sel),  8'h0);
    check_eq({tag, "_anode"},  8'(anode),      8'h7);
    check_eq({tag, "_blank"},  8'(blank),      8'h0);
    check_eq({tag, "_paused"}, 8'(paused),     8'h0);
    check_eq({tag, "_dp"},     8'(dp),         8'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_anode [5];
    exp_anode[0] = 4'b1011; exp_anode[1] = 4'b1101; exp_anode[2] = 4'b1110;
    exp_anode[3] = 4'b0111; exp_anode[4] = 4'b1011;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    step();

    // Normal run: 1 Hz ticks counted with carry, 2 Hz ignored
    for (int i = 0; i < 3; i++) begin
      do_tick1();
      check_eq("run_en", 8'(count_en), 8'h1);
      check_eq("run_mode", 8'(count_mode), 8'h0);
      do_tick2();
      check_eq("run_en_after", 8'(count_en), 8'h0);
      repeat (8) step();
    end

    // Pause toggles
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    check_eq("pause_on", 8'(paused), 8'h1);
    for (int i = 0; i < 5; i++) begin
      do_tick1();
      check_eq("paused_no_en", 8'(count_en), 8'h0);
      step();
    end
`ifndef SEQ_COLON_DP_EN
    check_eq("dp_off", 8'(dp), 8'h1);
`endif
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    check_eq("pause_off", 8'(paused), 8'h0);
    do_tick1();
    check_eq("resume_en", 8'(count_en), 8'h1);

    // Adjust seconds
    adjust_sw = 1'b1; select_sw = 1'b1;
    repeat (SYNC + 1) step();
    do_tick2();
    check_eq("adj_sec_en", 8'(count_en), 8'h1);
    check_eq("adj_sec_mode", 8'(count_mode), 8'h1);
    do_tick1();
    check_eq("adj_1hz_ignored", 8'(count_en), 8'h0);
    do_scan(); check_eq("blank_s_d1", 8'(blank), 8'h0);
    do_scan(); check_eq("blank_s_d2", 8'(blank), 8'h1);
    do_scan(); check_eq("blank_s_d3", 8'(blank), 8'h1);
    do_scan(); check_eq("blank_s_d0", 8'(blank), 8'h0);

    // Adjust minutes
    select_sw = 1'b0;
    repeat (SYNC + 1) step();
    do_tick2();
    check_eq("adj_min_en", 8'(count_en), 8'h1);
    check_eq("adj_min_mode", 8'(count_mode), 8'h2);
    step();
    check_eq("mode_hold_en", 8'(count_en), 8'h0);
    check_eq("mode_hold", 8'(count_mode), 8'h2);
    do_scan(); check_eq("blank_m_d1", 8'(blank), 8'h1);
    do_scan(); check_eq("blank_m_d2", 8'(blank), 8'h0);
    do_scan(); check_eq("blank_m_d3", 8'(blank), 8'h0);
    do_scan(); check_eq("blank_m_d0", 8'(blank), 8'h1);
    blink = 1'b1;
    do_scan(); check_eq("blank_blink_hi", 8'(blank), 8'h0);
    blink = 1'b0;
    repeat (3) do_scan();
    check_eq("digit_wrap", 8'(digit_sel), 8'h0);

    // Back to normal; clear wins over a coincident tick
    adjust_sw = 1'b0;
    repeat (SYNC + 1) step();
    clear_btn = 1'b1; tick_1hz = 1'b1; step(); clear_btn = 1'b0; tick_1hz = 1'b0;
    check_eq("clear_pulse", 8'(clear_o), 8'h1);
    check_eq("clear_drops_tick", 8'(count_en), 8'h0);
    step();
    check_eq("clear_one_cycle", 8'(clear_o), 8'h0);
    check_eq("clear_keeps_run", 8'(paused), 8'h0);
    do_tick1();
    check_eq("after_clear_en", 8'(count_en), 8'h1);
    pause_btn = 1'b1; tick_1hz = 1'b1; step(); pause_btn = 1'b0; tick_1hz = 1'b0;
    check_eq("pause_tick_en", 8'(count_en), 8'h1);
    check_eq("pause_tick_paused", 8'(paused), 8'h1);
    do_tick1();
    check_eq("paused_after", 8'(count_en), 8'h0);

    // Scan sequence
    for (int i = 0; i < 5; i++) begin
      do_scan();
      check_eq($sformatf("scan_anode%0d", i), 8'(anode), 8'(exp_anode[i]));
    end
    check_eq("scan_digit", 8'(digit_sel), 8'h1);
    check_eq("norm_no_blank", 8'(blank), 8'h0);

    // Enter ADJ_PAUSED, then reset asynchronously
    adjust_sw = 1'b1;
    repeat (SYNC + 1) step();
    do_tick2();
    check_eq("adjp_no_en", 8'(count_en), 8'h0);
    repeat (4) do_scan();
    check_eq("adjp_blank", 8'(blank), 8'h1);
    check_eq("adjp_paused", 8'(paused), 8'h1);
    check_eq("adjp_anode", 8'(anode), 8'hb);
    @(posedge clk);
    #3;
    rst = 1'b1;
    pause_btn = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    check_eq("held_btn_no_edge", 8'(paused), 8'h0);
    pause_btn = 1'b0; step();
    pause_btn = 1'b1; step(); pause_btn = 1'b0;
    check_eq("repress_edge", 8'(paused), 8'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
